// File: rtl/melody_recall_core.sv
// melody_recall_core
//   Melody memory game core. Plays the first cur_len notes of a stored
//   melody, then checks keypad entries note by note. Each fully correct round
//   grows the melody by one note. A round at MAX_NOTES length wins. Wrong keys
//   and input timeouts cost a life. The game is lost when no lives remain.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   seq_wr_en/seq_wr_data melody load (IDLE only); slot i = bits [i*NOTE_W +: NOTE_W]
//   start                 start a game (IDLE) or restart one (WIN/LOSE)
//   key_valid/key_code    one-cycle key strobe and its note code
//   tone_out/led_out      note being played or echoed (0 = silence)
//   playing, awaiting_key playback / key-wait status
//   cur_len, key_idx      round length and next expected key index
//   miss                  one-cycle pulse on a wrong key or a timeout
//   lives_left            remaining lives
//   game_won, game_over   terminal states
module melody_recall_core #(
    parameter  int NOTE_W        = 4,
    parameter  int MAX_NOTES     = 8,
    parameter  int START_LEN     = 3,
    parameter  int TONE_TICKS    = 4,
    parameter  int GAP_TICKS     = 2,
    parameter  int ECHO_TICKS    = 3,
    parameter  int LIVES         = 3,
    parameter  int INPUT_TIMEOUT = 0,
    localparam int LEN_W         = $clog2(MAX_NOTES + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        seq_wr_en,
    input  logic [NOTE_W*MAX_NOTES-1:0] seq_wr_data,
    input  logic                        start,
    input  logic                        key_valid,
    input  logic [NOTE_W-1:0]           key_code,
    output logic [NOTE_W-1:0]           tone_out,
    output logic [NOTE_W-1:0]           led_out,
    output logic                        playing,
    output logic                        awaiting_key,
    output logic [LEN_W-1:0]            cur_len,
    output logic [LEN_W-1:0]            key_idx,
    output logic                        miss,
    output logic [3:0]                  lives_left,
    output logic                        game_won,
    output logic                        game_over
);

    localparam int IDX_W   = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
    localparam int TMAX_A  = (TONE_TICKS > GAP_TICKS) ? TONE_TICKS : GAP_TICKS;
    localparam int TMAX    = (TMAX_A > ECHO_TICKS) ? TMAX_A : ECHO_TICKS;
    localparam int TICK_W  = $clog2(TMAX + 1);
    localparam int WT_W    = (INPUT_TIMEOUT > 0) ? $clog2(INPUT_TIMEOUT + 1) : 1;
    localparam int WT_LAST = (INPUT_TIMEOUT > 0) ? INPUT_TIMEOUT - 1 : 0;

    // S_MISS is a one-cycle silent state for timeouts: it carries the miss
    // pulse without an echo before the replay starts.
    typedef enum logic [2:0] {
        S_IDLE, S_PLAY_ON, S_PLAY_OFF, S_WAIT_KEY, S_ECHO, S_MISS, S_WIN, S_LOSE
    } state_t;

    state_t                             state_q, state_d;
    logic [MAX_NOTES-1:0][NOTE_W-1:0]   mel_q, mel_d;
    logic                               loaded_q, loaded_d;
    logic [LEN_W-1:0]                   cur_len_q, cur_len_d;
    logic [LEN_W-1:0]                   play_idx_q, play_idx_d;
    logic [LEN_W-1:0]                   key_idx_q, key_idx_d;
    logic [3:0]                         lives_q, lives_d;
    logic [TICK_W-1:0]                  tick_q, tick_d;
    logic [WT_W-1:0]                    wait_q, wait_d;
    logic [NOTE_W-1:0]                  echo_q, echo_d;
    logic                               match_q, match_d;
    logic                               do_miss, do_start;
    logic                               last_idx, timeout;

    assign last_idx = (key_idx_q == cur_len_q - LEN_W'(1));
    assign timeout  = (INPUT_TIMEOUT > 0) && (wait_q == WT_W'(WT_LAST));

    always_comb begin
        state_d    = state_q;
        mel_d      = mel_q;
        loaded_d   = loaded_q;
        cur_len_d  = cur_len_q;
        play_idx_d = play_idx_q;
        key_idx_d  = key_idx_q;
        lives_d    = lives_q;
        tick_d     = '0;
        wait_d     = '0;
        echo_d     = echo_q;
        match_d    = match_q;
        do_miss    = 1'b0;
        do_start   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (seq_wr_en) begin
                    mel_d    = seq_wr_data;
                    loaded_d = 1'b1;
                end
                // A melody written on the start cycle counts as loaded.
                if (start && (loaded_q || seq_wr_en)) do_start = 1'b1;
            end
            S_PLAY_ON: begin
                if (tick_q == TICK_W'(TONE_TICKS - 1)) state_d = S_PLAY_OFF;
                else                                   tick_d  = tick_q + TICK_W'(1);
            end
            S_PLAY_OFF: begin
                if (tick_q == TICK_W'(GAP_TICKS - 1)) begin
                    if (play_idx_q == cur_len_q - LEN_W'(1)) begin
                        state_d   = S_WAIT_KEY;
                        key_idx_d = '0;
                    end else begin
                        state_d    = S_PLAY_ON;
                        play_idx_d = play_idx_q + LEN_W'(1);
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_WAIT_KEY: begin
                // A key arriving on the timeout cycle takes priority.
                if (key_valid) begin
                    echo_d  = key_code;
                    match_d = (key_code == mel_q[key_idx_q[IDX_W-1:0]]);
                    state_d = S_ECHO;
                end else if (timeout) begin
                    state_d = S_MISS;
                end else if (INPUT_TIMEOUT > 0) begin
                    wait_d = wait_q + WT_W'(1);
                end
            end
            S_ECHO: begin
                if (tick_q == TICK_W'(ECHO_TICKS - 1)) begin
                    if (!match_q) begin
                        do_miss = 1'b1;
                    end else if (!last_idx) begin
                        state_d   = S_WAIT_KEY;
                        key_idx_d = key_idx_q + LEN_W'(1);
                    end else if (cur_len_q == LEN_W'(MAX_NOTES)) begin
                        state_d = S_WIN;
                    end else begin
                        state_d    = S_PLAY_ON;
                        cur_len_d  = cur_len_q + LEN_W'(1);
                        play_idx_d = '0;
                        key_idx_d  = '0;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            S_MISS: do_miss = 1'b1;
            S_WIN, S_LOSE: begin
                if (start) do_start = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (do_miss) begin
            lives_d    = lives_q - 4'd1;
            play_idx_d = '0;
            key_idx_d  = '0;
            state_d    = (lives_q == 4'd1) ? S_LOSE : S_PLAY_ON;
        end

        if (do_start) begin
            state_d    = S_PLAY_ON;
            cur_len_d  = LEN_W'(START_LEN);
            lives_d    = 4'(LIVES);
            play_idx_d = '0;
            key_idx_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mel_q      <= '0;
            loaded_q   <= 1'b0;
            cur_len_q  <= LEN_W'(START_LEN);
            play_idx_q <= '0;
            key_idx_q  <= '0;
            lives_q    <= 4'(LIVES);
            tick_q     <= '0;
            wait_q     <= '0;
            echo_q     <= '0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mel_q      <= mel_d;
            loaded_q   <= loaded_d;
            cur_len_q  <= cur_len_d;
            play_idx_q <= play_idx_d;
            key_idx_q  <= key_idx_d;
            lives_q    <= lives_d;
            tick_q     <= tick_d;
            wait_q     <= wait_d;
            echo_q     <= echo_d;
            match_q    <= match_d;
        end
    end

    always_comb begin
        tone_out = '0;
        case (state_q)
            S_PLAY_ON: tone_out = mel_q[play_idx_q[IDX_W-1:0]];
            S_ECHO:    tone_out = echo_q;
            default:   tone_out = '0;
        endcase
    end

    assign led_out      = tone_out;
    assign playing      = (state_q == S_PLAY_ON) || (state_q == S_PLAY_OFF);
    assign awaiting_key = (state_q == S_WAIT_KEY);
    assign cur_len      = cur_len_q;
    assign key_idx      = key_idx_q;
    assign lives_left   = lives_q;
    assign game_won     = (state_q == S_WIN);
    assign game_over    = (state_q == S_LOSE);
    // Wrong key: pulse on the first echo cycle. Timeout: pulse in S_MISS.
    assign miss         = ((state_q == S_ECHO) && (tick_q == '0) && !match_q) ||
                          (state_q == S_MISS);

endmodule
